// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the Sobel pixel pipeline.
//   Image size defaults, display-mode encodings, RGB width, pipeline
//   stage records, the 3x3 window type and the magnitude-to-nibble helper.
package vga_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int RGB_W     = 12;

  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_BIN  = 2'd1,
    MODE_MAG  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Window indexed [row][col]; row 0 is the top line, col 2 the newest column.
  typedef logic [2:0][2:0][7:0] win_t;

  // Position and timing carried through S1 and S2.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       in_img;
  } stage_t;

  // Everything S4 needs, captured at S3.
  typedef struct packed {
    logic        von;
    logic        hs;
    logic        vs;
    logic        in_img;
    logic        edge_ok;
    logic [3:0]  g;
    logic [10:0] mag;
  } tail_t;

  // Saturate the magnitude to 255 and keep the top nibble.
  function automatic logic [3:0] sat_nib(input logic [10:0] m);
    return (m > 11'd255) ? 4'hF : m[7:4];
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// sobel_kernel: combinational Sobel gradient magnitude.
//   i_win : 3x3 window of 8-bit pixels, [row][col]
//   o_mag : |Gx| + |Gy|, unsigned, max 2040
module sobel_kernel
  import vga_pkg::*;
(
  input  win_t        i_win,
  output logic [10:0] o_mag
);

  // Zero-extended pixel as signed 11-bit; all partial sums stay within +-1020.
  function automatic logic signed [10:0] sx(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [10:0] w_gx, w_gy;
  logic        [10:0] w_ax, w_ay;

  assign w_gx = (sx(i_win[0][2]) + (sx(i_win[1][2]) <<< 1) + sx(i_win[2][2]))
              - (sx(i_win[0][0]) + (sx(i_win[1][0]) <<< 1) + sx(i_win[2][0]));
  assign w_gy = (sx(i_win[2][0]) + (sx(i_win[2][1]) <<< 1) + sx(i_win[2][2]))
              - (sx(i_win[0][0]) + (sx(i_win[0][1]) <<< 1) + sx(i_win[0][2]));

  assign w_ax  = w_gx[10] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay  = w_gy[10] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign o_mag = w_ax + w_ay;

endmodule

// File: rtl/sobel_pixel_pipe.sv
// sobel_pixel_pipe: 4-stage pixel-rate pipeline between the VGA timing
// generator and the DAC, showing a grayscale ROM image as gray, binary
// edge or edge magnitude.
//   clk_100MHz, reset_n       : clock, async active-low reset
//   p_tick                    : pixel enable; the pipeline moves only on it
//   video_on, hsync_in,
//   vsync_in, x, y            : raster timing and position
//   mode, threshold           : display mode and binary-edge threshold (used at S4)
//   rom_addr / rom_data       : image ROM port, data one clk after address
//   rgb, hsync, vsync         : output pixel and timing, 3 ticks after sampling
module sobel_pixel_pipe
  import vga_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ROM_AW = 15
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [RGB_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync
);

  localparam int         LBW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] LP_W  = 10'(IMG_W);
  localparam logic [9:0] LP_H  = 10'(IMG_H);
  localparam logic [9:0] LP_W1 = 10'(IMG_W - 1);
  localparam logic [9:0] LP_H1 = 10'(IMG_H - 1);

  // ---------------- S1: sample raster, issue ROM read ----------------
  logic              w_in_img;
  logic [ROM_AW-1:0] w_addr;
  stage_t            r_s1;

  assign w_in_img = (x < LP_W) && (y < LP_H);
  assign w_addr   = ROM_AW'(int'(y) * IMG_W + int'(x));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '0;
      rom_addr <= '0;
    end else if (p_tick) begin
      r_s1     <= '{x: x, y: y, von: video_on, hs: hsync_in, vs: vsync_in, in_img: w_in_img};
      rom_addr <= w_in_img ? w_addr : '0;
    end
  end

  // ---------------- Line buffers ----------------
  // One RAM word per column holds {row y-2, row y-1}. The read port runs
  // every clk on the S1 column, so its registered output has settled long
  // before the next tick (ticks are at least 4 clks apart). Not reset:
  // stale rows are hidden by the y>=2 mask.
  logic [15:0]    r_lb [IMG_W];
  logic [15:0]    r_lb_q;
  logic [LBW-1:0] w_lb_a;

  assign w_lb_a = r_s1.x[LBW-1:0];

  always_ff @(posedge clk_100MHz) begin
    if (p_tick && r_s1.in_img) r_lb[w_lb_a] <= {r_lb_q[7:0], rom_data};
    r_lb_q <= r_lb[w_lb_a];
  end

  // ---------------- S2: shift column into window ----------------
  stage_t     r_s2;
  logic [3:0] r_s2_g;
  win_t       r_win;
  logic [7:0] w_col [3];

  assign w_col[0] = r_lb_q[15:8];
  assign w_col[1] = r_lb_q[7:0];
  assign w_col[2] = rom_data;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_s2   <= '0;
      r_s2_g <= '0;
      r_win  <= '0;
    end else if (p_tick) begin
      r_s2   <= r_s1;
      r_s2_g <= rom_data[7:4];
      if (r_s1.in_img) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
          r_win[r][2] <= w_col[r];
        end
      end
    end
  end

  // ---------------- S3: gradient magnitude ----------------
  // Window centre is pixel (x-1, y-1); all nine taps belong to the current
  // frame and line only inside the 2..W-1 / 2..H-1 box.
  logic [10:0] w_mag;
  logic        w_edge_ok;
  tail_t       r_s3;

  sobel_kernel u_kernel (
    .i_win (r_win),
    .o_mag (w_mag)
  );

  assign w_edge_ok = (r_s2.x >= 10'd2) && (r_s2.x <= LP_W1) &&
                     (r_s2.y >= 10'd2) && (r_s2.y <= LP_H1);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_s3 <= '0;
    end else if (p_tick) begin
      r_s3 <= '{von: r_s2.von, hs: r_s2.hs, vs: r_s2.vs, in_img: r_s2.in_img,
                edge_ok: w_edge_ok, g: r_s2_g, mag: w_mag};
    end
  end

  // ---------------- S4: colour select ----------------
  // mode/threshold are taken live here so a change needs no flush.
  logic [RGB_W-1:0] w_rgb;

  always_comb begin
    w_rgb = '0;
    if (r_s3.von && r_s3.in_img) begin
      unique case (mode_e'(mode))
        MODE_GRAY: w_rgb = {3{r_s3.g}};
        MODE_BIN:  if (r_s3.edge_ok && (r_s3.mag > {3'b000, threshold})) w_rgb = '1;
        MODE_MAG:  if (r_s3.edge_ok) w_rgb = {3{sat_nib(r_s3.mag)}};
        default:   w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      rgb   <= w_rgb;
      hsync <= r_s3.hs;
      vsync <= r_s3.vs;
    end
  end

endmodule

// File: tb/tb_sobel_pixel_pipe.sv
// tb_sobel_pixel_pipe: randomized raster stimulus with an image-domain
// Sobel reference model; expected pixels are queued at issue and popped
// by an independent monitor on every pixel tick.
module tb_sobel_pixel_pipe;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int AW = 8;
  localparam int HT = W + 4;   // raster line incl. horizontal blanking
  localparam int VT = H + 2;   // raster frame incl. vertical blanking

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p_tick = 1'b0;
  logic          von = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [9:0]    x = '0, y = '0;
  logic [1:0]    mode = '0;
  logic [7:0]    thr = '0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [11:0]   rgb;
  logic          hs, vs;

  logic [7:0] img [256];

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        chk;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_tick = 0;

  sobel_pixel_pipe #(.IMG_W(W), .IMG_H(H), .ROM_AW(AW)) dut (
    .clk_100MHz (clk),
    .reset_n    (rst_n),
    .p_tick     (p_tick),
    .video_on   (von),
    .hsync_in   (hs_in),
    .vsync_in   (vs_in),
    .x          (x),
    .y          (y),
    .mode       (mode),
    .threshold  (thr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb        (rgb),
    .hsync      (hs),
    .vsync      (vs)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= img[rom_addr];

  // ---------------- reference model ----------------
  function automatic int px(int xx, int yy);
    return int'(img[yy * W + xx]);
  endfunction

  function automatic logic [11:0] model(int xx, int yy, bit v, int m, int t);
    int cx, cy, gx, gy, mag;
    if (!v || xx >= W || yy >= H) return 12'h000;
    if (m == 0) return 12'((px(xx, yy) / 16) * 273);
    if (m == 3) return 12'h000;
    if (xx < 2 || xx > W - 1 || yy < 2 || yy > H - 1) return 12'h000;
    cx = xx - 1;
    cy = yy - 1;
    gx = (px(cx+1, cy-1) + 2*px(cx+1, cy) + px(cx+1, cy+1))
       - (px(cx-1, cy-1) + 2*px(cx-1, cy) + px(cx-1, cy+1));
    gy = (px(cx-1, cy+1) + 2*px(cx, cy+1) + px(cx+1, cy+1))
       - (px(cx-1, cy-1) + 2*px(cx, cy-1) + px(cx+1, cy-1));
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m == 1) return (mag > t) ? 12'hFFF : 12'h000;
    if (mag > 255) mag = 255;
    return 12'((mag / 16) * 273);
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at a negedge 4..6 clks later.
  task automatic tick(int xx, int yy, bit chk);
    x      = 10'(xx);
    y      = 10'(yy);
    von    = ($urandom % 8) != 0;
    hs_in  = 1'($urandom % 2);
    vs_in  = 1'($urandom % 2);
    p_tick = 1'b1;
    q.push_back('{rgb: model(xx, yy, von, int'(mode), int'(thr)), hs: hs_in, vs: vs_in, chk: chk});
    @(negedge clk);
    p_tick = 1'b0;
    // junk between ticks must not disturb the pipeline
    x      = 10'($urandom);
    y      = 10'($urandom);
    von    = 1'($urandom);
    hs_in  = 1'($urandom);
    vs_in  = 1'($urandom);
    repeat ($urandom_range(3, 5)) @(negedge clk);
  endtask

  task automatic frame(int i0, int i1, bit chk);
    for (int i = i0; i < i1; i++) tick(i % HT, i / HT, chk);
  endtask

  // Outputs of the three tick edges after reset come from cleared stages.
  task automatic prefill();
    repeat (3) q.push_back('{rgb: 12'h000, hs: 1'b0, vs: 1'b0, chk: 1'b1});
  endtask

  task automatic chk_rst(string tag);
    n_vec++;
    if (rgb !== 12'h000 || hs !== 1'b0 || vs !== 1'b0 || rom_addr !== '0) begin
      n_err++;
      $display("FAIL reset_%s rgb=%h hs=%b vs=%b rom_addr=%h required all zero",
               tag, rgb, hs, vs, rom_addr);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (p_tick && rst_n) begin
        #1;
        n_tick++;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL queue_empty tick=%0d rgb=%h, required a queued expectation", n_tick, rgb);
        end else begin
          e = q.pop_front();
          n_vec++;
          if ((e.chk && rgb !== e.rgb) || hs !== e.hs || vs !== e.vs) begin
            n_err++;
            $display("FAIL pixel tick=%0d rgb=%h req=%h(chk=%0b) hsync=%b req=%b vsync=%b req=%b",
                     n_tick, rgb, e.rgb, e.chk, hs, e.hs, vs, e.vs);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL timeout: stimulus did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h80;
    repeat (3) @(negedge clk);
    chk_rst("init");
    rst_n = 1'b1;
    prefill();

    // flat image: no edges anywhere, even in the first frame after reset
    mode = 2'd1; thr = 8'd0;
    frame(0, HT * VT, 1'b1);
    frame(0, HT * VT, 1'b1);

    // vertical step at column W/2
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) img[yy * W + xx] = (xx < W / 2) ? 8'h00 : 8'hFF;
    mode = 2'd1; thr = 8'd100;  frame(0, HT * VT, 1'b1);
    mode = 2'd2;                frame(0, HT * VT, 1'b1);
    mode = 2'd0;                frame(0, HT * VT, 1'b1);

    // single bright pixel at (10,10)
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[10 * W + 10] = 8'hFF;
    mode = 2'd0;                frame(0, HT * VT, 1'b1);
    mode = 2'd2;                frame(0, HT * VT, 1'b1);

    // random images in every mode
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    mode = 2'd1; thr = 8'($urandom_range(30, 220)); frame(0, HT * VT, 1'b1);
    mode = 2'd2;                frame(0, HT * VT, 1'b1);
    mode = 2'd3;                frame(0, HT * VT, 1'b1);
    mode = 2'd0;                frame(0, HT * VT, 1'b1);

    // reset mid-line, then resume mid-frame; rgb of that partial frame is
    // unchecked, the following full frames must be exact
    frame(0, 5 * HT + 7, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_rst("midline");
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prefill();
    frame(7 * HT + 3, HT * VT, 1'b0);
    mode = 2'd1; thr = 8'($urandom_range(30, 220)); frame(0, HT * VT, 1'b1);
    mode = 2'd2;                frame(0, HT * VT, 1'b1);

    // drain the last three in-flight pixels
    repeat (3) tick(HT - 1, VT - 1, 1'b1);
    repeat (4) @(negedge clk);
    if (q.size() != 3) begin
      n_vec++;
      n_err++;
      $display("FAIL drain queue_size=%0d required 3", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_pixel_pipe.md
SOBEL_PIXEL_PIPE -- requirements
Module: sobel_pixel_pipe

Interface
REQ-001 SHALL have parameter IMG_W, default 160, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 120, source image height in pixels.
REQ-003 SHALL have parameter ROM_AW, default 15, image ROM address width.
REQ-004 SHALL have port clk_100MHz  in  1  system clock; the block's only clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port p_tick  in  1  pixel-rate enable, one clk wide, at most one per 4 clks.
REQ-007 SHALL have port video_on, hsync_in, vsync_in  in  1 each  raster timing from the VGA timing stage.
REQ-008 SHALL have port x, y  in  10 each  current raster position.
REQ-009 SHALL have port mode  in  2  display mode: 0 gray, 1 binary edge, 2 edge magnitude, 3 reserved.
REQ-010 SHALL have port threshold  in  8  binary-edge threshold.
REQ-011 SHALL have port rom_addr  out  ROM_AW  8-bit grayscale image ROM address.
REQ-012 SHALL have port rom_data  in  8  ROM read data, valid 1 clk after rom_addr.
REQ-013 SHALL have port rgb  out  12  4:4:4 pixel colour.
REQ-014 SHALL have port hsync, vsync  out  1 each  timing delayed to align with rgb.

Function
REQ-015 The pipeline SHALL advance only on clk edges where p_tick=1; all state SHALL hold otherwise.
REQ-016 S1 on tick: register x, y, video_on, syncs, and in_img=(x<IMG_W && y<IMG_H); rom_addr SHALL be registered as y*IMG_W+x, or 0 when !in_img.
REQ-017 S2 on next tick, if in_img: shift a new column {lb1[x], lb0[x], rom_data} (top to bottom) into the 3x3 window; write lb1[x]<=lb0[x] and lb0[x]<=rom_data.
REQ-018 S3 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02) as signed 11-bit; mag=|Gx|+|Gy| as unsigned 11-bit, with no overflow (max 2040).
REQ-019 Window centre corresponds to image pixel (x-1, y-1) of the S2 position; edge output SHALL be valid only when 2<=x<=IMG_W-1 and 2<=y<=IMG_H-1, else black.
REQ-020 S4 SHALL register rgb: mode 0 = {g,g,g}, g=pixel(x,y)[7:4], no border mask; mode 1 = 12'hFFF if mag>threshold else 0; mode 2 = {m,m,m}, m=sat255(mag)[7:4]; mode 3 = 0.
REQ-021 rgb SHALL be 0 whenever the aligned video_on=0 or in_img=0.
REQ-022 hsync/vsync SHALL be hsync_in/vsync_in delayed exactly 3 p_ticks, matching rgb latency of 3 p_ticks from x/y sampling.
REQ-023 A mode or threshold change SHALL take effect at the S4 register; no pipeline flush.
REQ-024 Positions with x>=IMG_W SHALL NOT write line buffers or shift the window.

Reset
REQ-025 On reset_n=0, rgb, hsync, vsync, rom_addr, all pipeline and sync-delay registers, and the window SHALL clear to 0 immediately.
REQ-026 Line-buffer RAM SHALL NOT be reset; masking (REQ-019) SHALL make the first valid edge pixel independent of stale contents.
REQ-027 Reset release mid-frame SHALL produce correct edge output from the first full frame after release.

Structure
REQ-028 IMG_W/IMG_H defaults, mode encodings and the RGB width SHALL live in shared package vga_pkg.
REQ-029 The Sobel arithmetic (window in, mag out) SHALL be one sub-module, sobel_kernel; line buffers SHALL be inferred as block RAM.

Verification
REQ-030 Reset: assert reset_n=0 mid-line -> rgb=0, hsync=0, vsync=0 on the same clk edge.
REQ-031 Flat image (all 0x80), mode 1, threshold 0 -> rgb=0 at every pixel.
REQ-032 Vertical step (cols<80 = 0x00, else 0xFF), mode 1, threshold 100 -> rgb=12'hFFF at display x=80..81 for y=2..119, 0 elsewhere.
REQ-033 Same step image, mode 2 -> rgb=12'hFFF at the edge columns (mag 1020 saturated); mode 0 -> rgb=12'h000 / 12'hFFF left/right of x=80.
REQ-034 Latency: single 0xFF pixel at (10,10), mode 0 -> rgb=12'hFFF exactly 3 p_ticks after x=10, y=10 is sampled; hsync edges lag hsync_in by 3 p_ticks.
REQ-035 Borders: x=1, y=1, x=IMG_W-1 check, and x>=160 or y>=120 -> rgb=0 in modes 1 and 2.
